// File: rtl/grant_decoder_2to4.sv
// Turns the winning requester's 2-bit code into a one-hot grant.
// The grant is held until done or until HOLD_MAX cycles pass, then one recover cycle follows.
module grant_decoder_2to4 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] code,
    input  logic       valid,
    input  logic       done,
    output logic       ready,
    output logic [3:0] grant,
    output logic       busy,
    output logic [1:0] last_code,
    output logic       timeout
);

    typedef enum logic [1:0] {StIdle, StGrant, StRecover} state_e;

    // Count value on the last allowed grant cycle; the counter never passes it.
    localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       ready_q, ready_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic [1:0] last_code_q, last_code_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        ready_d     = ready_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        last_code_d = last_code_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    state_d     = StGrant;
                    hold_d      = 8'd0;
                    ready_d     = 1'b0;
                    grant_d     = 4'b0001 << code;
                    busy_d      = 1'b1;
                    last_code_d = code;
                end
            end
            StGrant: begin
                // done has priority over an expiring hold, so no timeout pulse then
                if (done) begin
                    state_d = StRecover;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end else if (hold_q == HoldLast) begin
                    state_d   = StRecover;
                    grant_d   = 4'b0000;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            StRecover: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= 8'd0;
            ready_q     <= 1'b1;
            grant_q     <= 4'b0000;
            busy_q      <= 1'b0;
            last_code_q <= 2'b00;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ready_q     <= ready_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            last_code_q <= last_code_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ready     = ready_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign last_code = last_code_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_grant_decoder_2to4.sv
// Directed bench for grant_decoder_2to4 (HOLD_MAX=4): a grant-age model checked every
// falling edge, plus hand-computed literal expectations along the stimulus.
module tb_grant_decoder_2to4;

    localparam int unsigned Hold = 4;

    logic       clk;
    logic       rst;
    logic [1:0] code;
    logic       valid;
    logic       done;
    logic       ready;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] last_code;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    grant_decoder_2to4 #(.HOLD_MAX(Hold)) dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .valid     (valid),
        .done      (done),
        .ready     (ready),
        .grant     (grant),
        .busy      (busy),
        .last_code (last_code),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    endtask

    // Model: who owns the grant, how many cycles it has been visible, recover flag.
    bit       m_granted;
    bit       m_recover;
    bit       m_to;
    int       m_age;
    int       m_code;
    int       m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_granted <= 0;
            m_recover <= 0;
            m_to      <= 0;
            m_age     <= 0;
            m_code    <= 0;
            m_last    <= 0;
        end else begin
            m_to <= 0;
            if (m_recover) begin
                m_recover <= 0;
            end else if (!m_granted) begin
                if (valid) begin
                    m_granted <= 1;
                    m_code    <= int'(code);
                    m_last    <= int'(code);
                    m_age     <= 1;
                end
            end else if (done) begin
                m_granted <= 0;
                m_recover <= 1;
            end else if (m_age == int'(Hold)) begin
                m_granted <= 0;
                m_recover <= 1;
                m_to      <= 1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("mdl_grant", 32'(grant), m_granted ? (32'd1 << m_code) : 32'd0);
        check("mdl_busy", 32'(busy), 32'(m_granted));
        check("mdl_ready", 32'(ready), 32'(!m_granted && !m_recover));
        check("mdl_timeout", 32'(timeout), 32'(m_to));
        check("mdl_last_code", 32'(last_code), 32'(m_last));
        check("onehot0", 32'($countones(grant) <= 1), 32'd1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [3:0] exp_g [4];

    initial begin
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000;
        rst = 1'b1; valid = 1'b0; done = 1'b0; code = 2'd0;
        cyc();
        cyc();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_last_code", 32'(last_code), 32'd0);
        rst = 1'b0;
        cyc();

        // Decode sweep
        for (int c = 0; c < 4; c++) begin
            code = 2'(c); valid = 1'b1;
            cyc();
            check("sweep_grant", 32'(grant), 32'(exp_g[c]));
            check("sweep_last_code", 32'(last_code), 32'(c));
            check("sweep_busy1", 32'(busy), 32'd1);
            valid = 1'b0;
            cyc();
            check("sweep_busy2", 32'(busy), 32'd1);
            check("sweep_hold", 32'(grant), 32'(exp_g[c]));
            done = 1'b1;
            cyc();
            check("sweep_rec_grant", 32'(grant), 32'd0);
            check("sweep_rec_ready", 32'(ready), 32'd0);
            done = 1'b0;
            cyc();
            check("sweep_idle_ready", 32'(ready), 32'd1);
        end

        // Timeout: grant visible exactly Hold cycles
        code = 2'd2; valid = 1'b1;
        cyc();
        check("to_grant_1", 32'(grant), 32'h4);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("to_grant_n", 32'(grant), 32'h4);
            check("to_no_pulse", 32'(timeout), 32'd0);
        end
        cyc();
        check("to_drop", 32'(grant), 32'd0);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_rec_ready", 32'(ready), 32'd0);
        cyc();
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_ready", 32'(ready), 32'd1);

        // Done on the 4th grant cycle beats the timeout
        code = 2'd1; valid = 1'b1;
        cyc();
        valid = 1'b0;
        cyc();
        cyc();
        cyc();
        check("col_grant4", 32'(grant), 32'h2);
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("col_timeout", 32'(timeout), 32'd0);
        check("col_drop", 32'(grant), 32'd0);
        check("col_rec_ready", 32'(ready), 32'd0);
        cyc();
        check("col_ready", 32'(ready), 32'd1);

        // Back-to-back: accepts every 3 cycles
        code = 2'd3; valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            case (k % 3)
                0: begin
                    check("b2b_grant", 32'(grant), 32'h8);
                    check("b2b_ready_g", 32'(ready), 32'd0);
                    done = 1'b1;
                end
                1: begin
                    check("b2b_rec_grant", 32'(grant), 32'd0);
                    check("b2b_ready_r", 32'(ready), 32'd0);
                    done = 1'b0;
                end
                default: begin
                    check("b2b_idle_grant", 32'(grant), 32'd0);
                    check("b2b_ready_i", 32'(ready), 32'd1);
                end
            endcase
        end
        valid = 1'b0;
        cyc();

        // Inputs ignored during GRANT, done ignored in IDLE
        code = 2'd0; valid = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            code = 2'(3 - i); valid = (i == 0) ? 1'b0 : 1'b1;
            cyc();
            check("ign_grant", 32'(grant), 32'h1);
            check("ign_last_code", 32'(last_code), 32'd0);
        end
        valid = 1'b0; done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("idle_done_ready", 32'(ready), 32'd1);
            check("idle_done_grant", 32'(grant), 32'd0);
        end
        done = 1'b0;

        // Reset asserted between edges mid-grant
        code = 2'd1; valid = 1'b1;
        cyc();
        valid = 1'b0;
        check("mid_pre_grant", 32'(grant), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_last", 32'(last_code), 32'd0);
        cyc();
        rst = 1'b0; code = 2'd2; valid = 1'b1;
        cyc();
        check("post_rst_grant", 32'(grant), 32'h4);
        check("post_rst_last", 32'(last_code), 32'd2);
        valid = 1'b0; done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
